// File: rtl/snoop_arbiter_pkg.sv
// Shared definitions for the snoop arbiter.
//   - arb_state_e     : IDLE/LOCKED arbitration state
//   - tag layout      : {valid, index}; valid is the MSB, index fills the LSBs
//   - tag_vld_bit()   : bit position of the valid flag for a given tag width
//   - onehot_from_idx(): MAX_CORES-wide one-hot; callers size-cast to N bits
package snoop_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_CORES = 64;

  function automatic int unsigned tag_vld_bit(input int unsigned tag_sz);
    return tag_sz - 1;
  endfunction

  function automatic logic [MAX_CORES-1:0] onehot_from_idx(input int unsigned idx);
    logic [MAX_CORES-1:0] one;
    one = {{(MAX_CORES-1){1'b0}}, 1'b1};
    if (idx < MAX_CORES) return one << idx;
    return '0;
  endfunction

endpackage

// File: rtl/snoop_arbiter_tag_tree.sv
// Pairwise reduction of per-core ready bits into a single {valid,index} tag
// naming the lowest-index ready core, with an optional output register.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset (clears the register)
//   rdy_vec[N]   : per-core ready
//   cand[TAG_SZ] : selected tag, registered when DELAY_CONF=1
module snoop_arbiter_tag_tree
  import snoop_arbiter_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned TAG_SZ     = 5,
  parameter int unsigned DELAY_CONF = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      rdy_vec,
  output logic [TAG_SZ-1:0] cand
);

  localparam int unsigned IW  = TAG_SZ - 1;
  localparam int unsigned VLD = tag_vld_bit(TAG_SZ);
  localparam int unsigned LVL = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NP  = 1 << LVL;

  // Pad to a power of two; padding leaves are never valid.
  logic [NP-1:0]     rdy_pad;
  logic [TAG_SZ-1:0] tree_out;

  assign rdy_pad = NP'(rdy_vec);

  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    logic [TAG_SZ-1:0] t [NP >> l];
    for (genvar j = 0; j < (NP >> l); j++) begin : g_t
      if (l == 0) begin : g_leaf
        assign t[j] = {rdy_pad[j], IW'(j)};
      end else begin : g_red
        // Left child covers the lower indices, so it wins whenever valid.
        assign t[j] = g_lvl[l-1].t[2*j][VLD] ? g_lvl[l-1].t[2*j] : g_lvl[l-1].t[2*j+1];
      end
    end
  end

  assign tree_out = g_lvl[LVL].t[0];

  if (DELAY_CONF != 0) begin : g_reg
    logic [TAG_SZ-1:0] cand_q, cand_d;

    always_comb cand_d = tree_out;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cand_q <= '0;
      else      cand_q <= cand_d;
    end

    assign cand = cand_q;
  end else begin : g_comb
    assign cand = tree_out;
  end

endmodule

// File: rtl/snoop_arbiter.sv
// Arbitrates the single packet snooper onto one of N packetfilter cores.
// A core is picked (lowest-index ready), granted on ack, and the snooper's
// write/done strobes are steered to it until done releases the lock.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   addr, wr_data, byte_inc  : snooper data, broadcast as sn_addr/sn_wr_data/sn_byte_inc
//   wr_en, done, ack         : snooper strobes
//   rdy                      : a core is available to (or reserved for) the snooper
//   rdy_for_sn[N]            : per-core ready
//   sn_wr_en, sn_done[N]     : one-hot strobes to the locked core
//   rdy_for_sn_ack[N]        : one-hot grant acknowledge to the chosen core
module snoop_arbiter
  import snoop_arbiter_pkg::*;
#(
  parameter int unsigned SN_ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned INC_WIDTH     = 8,
  parameter int unsigned N             = 4,
  parameter int unsigned TAG_SZ        = 5,
  parameter int unsigned DELAY_CONF    = 1,
  parameter int unsigned PESS          = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SN_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_en,
  input  logic [INC_WIDTH-1:0]     byte_inc,
  input  logic                     done,
  input  logic                     ack,
  output logic                     rdy,
  input  logic [N-1:0]             rdy_for_sn,
  output logic [SN_ADDR_WIDTH-1:0] sn_addr,
  output logic [DATA_WIDTH-1:0]    sn_wr_data,
  output logic [INC_WIDTH-1:0]     sn_byte_inc,
  output logic [N-1:0]             sn_wr_en,
  output logic [N-1:0]             sn_done,
  output logic [N-1:0]             rdy_for_sn_ack
);

  localparam int unsigned IW  = TAG_SZ - 1;
  localparam int unsigned VLD = tag_vld_bit(TAG_SZ);

  logic [TAG_SZ-1:0] cand;
  logic              cand_vld;
  logic [IW-1:0]     cand_idx;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic          post_done_q, post_done_d;

  assign sn_addr     = addr;
  assign sn_wr_data  = wr_data;
  assign sn_byte_inc = byte_inc;

  snoop_arbiter_tag_tree #(
    .N          (N),
    .TAG_SZ     (TAG_SZ),
    .DELAY_CONF (DELAY_CONF)
  ) u_tag_tree (
    .clk     (clk),
    .rst     (rst),
    .rdy_vec (rdy_for_sn),
    .cand    (cand)
  );

  assign cand_vld = cand[VLD];
  assign cand_idx = cand[IW-1:0];

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    post_done_d    = 1'b0;
    rdy            = 1'b0;
    sn_wr_en       = '0;
    sn_done        = '0;
    rdy_for_sn_ack = '0;
    case (state_q)
      ST_IDLE: begin
        // In pessimistic mode the candidate registered during the locked
        // packet may be stale, so hold off one cycle after release.
        rdy = cand_vld & ~((PESS != 0) & post_done_q);
        if (ack && rdy) begin
          rdy_for_sn_ack = N'(onehot_from_idx(32'(cand_idx)));
          sel_d          = cand_idx;
          state_d        = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // The locked core's ready is deliberately not re-checked here.
        rdy = 1'b1;
        if (wr_en) sn_wr_en = N'(onehot_from_idx(32'(sel_q)));
        if (done) begin
          sn_done     = N'(onehot_from_idx(32'(sel_q)));
          state_d     = ST_IDLE;
          post_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      post_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      post_done_q <= post_done_d;
    end
  end

endmodule

// File: tb/tb_snoop_arbiter.sv
module tb_snoop_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [63:0] wr_data;
  logic        wr_en;
  logic [7:0]  byte_inc;

  logic       done_a, ack_a, rdy_a;
  logic [3:0] rfs_a, sn_wr_en_a, sn_done_a, ack_oh_a;
  logic [7:0] sn_addr_a, sn_byte_inc_a;
  logic [63:0] sn_wr_data_a;

  logic       done_b, ack_b, rdy_b;
  logic [3:0] rfs_b, sn_wr_en_b, sn_done_b, ack_oh_b;
  logic [7:0] sn_addr_b, sn_byte_inc_b;
  logic [63:0] sn_wr_data_b;

  always #5 clk = ~clk;

  snoop_arbiter #(
    .SN_ADDR_WIDTH(8), .DATA_WIDTH(64), .INC_WIDTH(8), .N(4), .TAG_SZ(5),
    .DELAY_CONF(1), .PESS(0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .wr_en(wr_en),
    .byte_inc(byte_inc), .done(done_a), .ack(ack_a), .rdy(rdy_a),
    .rdy_for_sn(rfs_a), .sn_addr(sn_addr_a), .sn_wr_data(sn_wr_data_a),
    .sn_byte_inc(sn_byte_inc_a), .sn_wr_en(sn_wr_en_a), .sn_done(sn_done_a),
    .rdy_for_sn_ack(ack_oh_a)
  );

  snoop_arbiter #(
    .SN_ADDR_WIDTH(8), .DATA_WIDTH(64), .INC_WIDTH(8), .N(4), .TAG_SZ(5),
    .DELAY_CONF(1), .PESS(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .wr_en(wr_en),
    .byte_inc(byte_inc), .done(done_b), .ack(ack_b), .rdy(rdy_b),
    .rdy_for_sn(rfs_b), .sn_addr(sn_addr_b), .sn_wr_data(sn_wr_data_b),
    .sn_byte_inc(sn_byte_inc_b), .sn_wr_en(sn_wr_en_b), .sn_done(sn_done_b),
    .rdy_for_sn_ack(ack_oh_b)
  );

  typedef enum {S_RDY_A, S_ACK_A, S_WR_A, S_DONE_A, S_ADDR_A, S_DATA_A, S_INC_A,
                S_RDY_B, S_ACK_B, S_DONE_B} sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [63:0] exp;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] sample(input sig_e s);
    case (s)
      S_RDY_A:  return 64'(rdy_a);
      S_ACK_A:  return 64'(ack_oh_a);
      S_WR_A:   return 64'(sn_wr_en_a);
      S_DONE_A: return 64'(sn_done_a);
      S_ADDR_A: return 64'(sn_addr_a);
      S_DATA_A: return sn_wr_data_a;
      S_INC_A:  return 64'(sn_byte_inc_a);
      S_RDY_B:  return 64'(rdy_b);
      S_ACK_B:  return 64'(ack_oh_b);
      S_DONE_B: return 64'(sn_done_b);
      default:  return 64'hX;
    endcase
  endfunction

  task automatic push(input string nm, input sig_e s, input logic [63:0] v);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.exp = v; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic exp_a(input string nm, input logic r, input logic [3:0] ak,
                       input logic [3:0] wr, input logic [3:0] dn);
    push(nm, S_RDY_A, 64'(r));
    push(nm, S_ACK_A, 64'(ak));
    push(nm, S_WR_A, 64'(wr));
    push(nm, S_DONE_A, 64'(dn));
  endtask

  task automatic exp_b(input string nm, input logic r, input logic [3:0] ak,
                       input logic [3:0] dn);
    push(nm, S_RDY_B, 64'(r));
    push(nm, S_ACK_B, 64'(ak));
    push(nm, S_DONE_B, 64'(dn));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: compare every expectation that belongs to the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        exp_t e;
        logic [63:0] act;
        e   = sbq.pop_front();
        act = sample(e.sig);
        checks++;
        if (e.cyc != cyc || act !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d sig=%s actual=%0h required=%0h (expected at cyc %0d)",
                   e.nm, cyc, e.sig.name(), act, e.exp, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; addr = '0; wr_data = '0; byte_inc = '0;
    rfs_a = 4'b1111; rfs_b = 4'b1111;
    ack_a = 1'b1; ack_b = 1'b1; wr_en = 1'b1; done_a = 1'b1; done_b = 1'b1;
    tick();
    repeat (2) begin
      exp_a("reset", 1'b0, 4'b0000, 4'b0000, 4'b0000);
      exp_b("reset", 1'b0, 4'b0000, 4'b0000);
      tick();
    end

    rst = 1'b1; rfs_a = 4'b0000; rfs_b = 4'b0000;
    ack_a = 1'b0; ack_b = 1'b0; wr_en = 1'b0; done_a = 1'b0; done_b = 1'b0;
    tick();

    // Candidate lags rdy_for_sn by one cycle.
    rfs_a = 4'b0110;
    exp_a("grant_lag", 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tick();
    ack_a = 1'b1; wr_en = 1'b1;
    exp_a("grant", 1'b1, 4'b0010, 4'b0000, 4'b0000);
    tick();
    ack_a = 1'b0; addr = 8'h3C; wr_data = 64'hDEAD_BEEF_0123_4567; byte_inc = 8'h08;
    rfs_a = 4'b0000;
    exp_a("steer_wr", 1'b1, 4'b0000, 4'b0010, 4'b0000);
    push("steer_addr", S_ADDR_A, 64'h3C);
    push("steer_data", S_DATA_A, 64'hDEAD_BEEF_0123_4567);
    push("steer_inc", S_INC_A, 64'h08);
    tick();
    wr_en = 1'b0; ack_a = 1'b1;
    exp_a("steer_nowr", 1'b1, 4'b0000, 4'b0000, 4'b0000);
    tick();
    ack_a = 1'b0; done_a = 1'b1; rfs_a = 4'b0100;
    exp_a("release", 1'b1, 4'b0000, 4'b0000, 4'b0010);
    tick();
    done_a = 1'b0; ack_a = 1'b1;
    exp_a("regrant", 1'b1, 4'b0100, 4'b0000, 4'b0000);
    tick();
    ack_a = 1'b0; done_a = 1'b1; wr_en = 1'b1; rfs_a = 4'b0000;
    exp_a("wr_done", 1'b1, 4'b0000, 4'b0100, 4'b0100);
    tick();
    done_a = 1'b0; wr_en = 1'b0; ack_a = 1'b1;
    exp_a("no_ready", 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tick();
    ack_a = 1'b0; wr_en = 1'b1; done_a = 1'b1; rfs_a = 4'b1000;
    exp_a("idle_ignore", 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tick();
    wr_en = 1'b0; done_a = 1'b0; ack_a = 1'b1;
    exp_a("grant3", 1'b1, 4'b1000, 4'b0000, 4'b0000);
    tick();
    // Reset while locked with done and wr_en high: nothing may escape.
    ack_a = 1'b0; done_a = 1'b1; wr_en = 1'b1; rst = 1'b0;
    exp_a("rst_mid", 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tick();
    rst = 1'b1; done_a = 1'b0; wr_en = 1'b0; rfs_a = 4'b1010;
    exp_a("post_rst", 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tick();
    ack_a = 1'b1;
    exp_a("lowest", 1'b1, 4'b0010, 4'b0000, 4'b0000);
    tick();
    ack_a = 1'b0; done_a = 1'b1;
    exp_a("release1", 1'b1, 4'b0000, 4'b0000, 4'b0010);
    tick();
    done_a = 1'b0; rfs_a = 4'b0000;
    exp_a("opt_reassert", 1'b1, 4'b0000, 4'b0000, 4'b0000);
    tick();

    // Pessimistic instance.
    rfs_b = 4'b1111;
    exp_b("b_lag", 1'b0, 4'b0000, 4'b0000);
    tick();
    ack_b = 1'b1;
    exp_b("b_grant", 1'b1, 4'b0001, 4'b0000);
    tick();
    ack_b = 1'b0; done_b = 1'b1;
    exp_b("b_release", 1'b1, 4'b0000, 4'b0001);
    tick();
    done_b = 1'b0; ack_b = 1'b1;
    exp_b("b_pess_hold", 1'b0, 4'b0000, 4'b0000);
    tick();
    exp_b("b_regrant", 1'b1, 4'b0001, 4'b0000);
    tick();
    ack_b = 1'b0;
    exp_b("b_locked", 1'b1, 4'b0000, 4'b0000);
    tick();

    repeat (2) tick();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snoop_arbiter.md
SNOOP_ARBITER -- requirements
Module: snoop_arb

Interface
REQ-001 SHALL have parameter SN_ADDR_WIDTH, default 8, the snooper write-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the write-data width.
REQ-003 SHALL have parameter INC_WIDTH, default 8, the byte-increment width.
REQ-004 SHALL have parameter N, default 4, the number of packetfilter cores.
REQ-005 SHALL have parameter TAG_SZ, default 5, the tag width (1 valid bit plus index); TAG_SZ-1 >= clog2(N).
REQ-006 SHALL have parameter DELAY_CONF, default 1: 1 registers the tag-tree result, 0 makes it combinational.
REQ-007 SHALL have parameter PESS, default 0: 1 selects pessimistic re-arbitration.
REQ-008 SHALL have port clk, input, 1 bit; the single clock; all state on rising edge.
REQ-009 SHALL have port rst, input, 1 bit; asynchronous active-low reset.
REQ-010 SHALL have inputs addr [SN_ADDR_WIDTH], wr_data [DATA_WIDTH], wr_en [1], byte_inc [INC_WIDTH], done [1], ack [1]; all from the snooper.
REQ-011 SHALL have output rdy, 1 bit; a core is available to, or reserved for, the snooper.
REQ-012 SHALL have input rdy_for_sn, N bits; per-core ready.
REQ-013 SHALL have outputs sn_addr [SN_ADDR_WIDTH], sn_wr_data [DATA_WIDTH] and sn_byte_inc [INC_WIDTH], shared by all cores.
REQ-014 SHALL have outputs sn_wr_en [N], sn_done [N] and rdy_for_sn_ack [N], one-hot to the selected core.

Function
REQ-015 sn_addr, sn_wr_data and sn_byte_inc SHALL equal addr, wr_data and byte_inc combinationally at all times.
REQ-016 Candidate SHALL be the lowest-index set bit of rdy_for_sn, computed by tag tree as {valid,index}.
REQ-017 Candidate SHALL lag rdy_for_sn by exactly one cycle when DELAY_CONF=1, and zero cycles when DELAY_CONF=0.
REQ-018 State SHALL be IDLE or LOCKED, with a registered index sel.
REQ-019 In IDLE, rdy SHALL equal candidate valid (PESS=0).
REQ-020 In LOCKED, rdy SHALL be 1.
REQ-021 In IDLE with ack=1 and rdy=1: rdy_for_sn_ack SHALL be onehot(candidate) in that cycle, sel SHALL take the candidate, and the state SHALL go to LOCKED next edge.
REQ-022 In IDLE with ack=1 and rdy=0: ack SHALL be ignored and rdy_for_sn_ack SHALL be 0.
REQ-023 In LOCKED: sn_wr_en SHALL be onehot(sel) when wr_en=1, else 0.
REQ-024 In LOCKED: sn_done SHALL be onehot(sel) when done=1, else 0.
REQ-025 In LOCKED: rdy_for_sn_ack SHALL be 0 and ack SHALL be ignored.
REQ-026 In LOCKED with done=1, the state SHALL go to IDLE at the next edge.
REQ-027 In IDLE, sn_wr_en and sn_done SHALL be 0 regardless of wr_en and done.
REQ-028 The arbiter SHALL NOT check rdy_for_sn[sel] dropping while LOCKED; it SHALL stay LOCKED until done.
REQ-029 PESS=1: rdy SHALL be forced 0 for the first IDLE cycle after done, so the candidate refreshes before the next grant.
REQ-030 PESS=0: rdy SHALL be allowed to reassert in the cycle immediately after done.
REQ-031 At most one bit of sn_wr_en, sn_done and rdy_for_sn_ack SHALL ever be set.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, sel=0 and the registered candidate invalid.
REQ-033 Consequently rdy, sn_wr_en, sn_done and rdy_for_sn_ack SHALL be 0 during reset.
REQ-034 Reset asserted mid-packet SHALL drop the lock without emitting sn_done.

Structure
REQ-035 Tag layout (valid bit MSB, index LSBs) and the onehot-from-index helper SHALL live in a shared package.
REQ-036 Sub-module tag_tree SHALL be a log2(N)-level pairwise reduction of tags, preferring the lower index, with optional output register per DELAY_CONF.
REQ-037 Top SHALL contain the IDLE/LOCKED FSM, sel register and output steering; target 120-400 lines RTL.

Verification (N=4, DELAY_CONF=1, PESS=0)
REQ-038 Reset: hold rst=0 with rdy_for_sn=4'b1111 -> rdy=0 and all one-hot outputs 0.
REQ-039 Grant: rdy_for_sn=4'b0110 at cycle 0 -> rdy=1 at cycle 1; ack=1 at cycle 1 -> rdy_for_sn_ack=4'b0010 that cycle; LOCKED at cycle 2.
REQ-040 Steering: LOCKED on core1 with wr_en=1, addr=8'h3C -> sn_wr_en=4'b0010, sn_addr=8'h3C; with wr_en=0 -> sn_wr_en=0.
REQ-041 Release: done=1 while LOCKED on core1 -> sn_done=4'b0010 that cycle; next cycle IDLE; rdy_for_sn=4'b0100 -> next grant on core2 (rdy_for_sn_ack=4'b0100).
REQ-042 No ready: rdy_for_sn=0 with ack=1 -> rdy=0, rdy_for_sn_ack=0, state stays IDLE.
REQ-043 PESS=1 variant: cycle after done -> rdy=0 even with rdy_for_sn=4'b1111; following cycle rdy=1.
